status_event_queue: RTL

Downstream consumer of the 9-bit input-status word produced by the status/mux stage. Filters glitches by requiring a new status value to hold stable for a programmable number of samples. Each committed change is pushed as an event into a small FIFO, which is drained by the register/interrupt block over a valid/ready handshake. Dropped events are counted in an overflow counter.

---
 rtl/status_event_queue_pkg.sv | 29 ++
 rtl/status_event_queue_if.sv | 12 +
 rtl/status_evt_fifo.sv | 63 ++++++
 rtl/status_event_queue.sv | 125 ++++++++++++
 4 files changed

// File: rtl/status_event_queue_pkg.sv
// Shared widths, event word layout and filter FSM states for the status event queue.
// STATUS_EVT_TSTAMP_EN prepends an 8-bit commit timestamp to each event.
package status_event_queue_pkg;

  localparam int unsigned STATUS_W = 9;
  localparam int unsigned TSTAMP_W = 8;
  localparam int unsigned OVF_W    = 8;

`ifdef STATUS_EVT_TSTAMP_EN
  localparam int unsigned EVT_W = STATUS_W + TSTAMP_W;

  typedef struct packed {
    logic [TSTAMP_W-1:0] tstamp;
    logic [STATUS_W-1:0] status;
  } evt_t;
`else
  localparam int unsigned EVT_W = STATUS_W;

  typedef struct packed {
    logic [STATUS_W-1:0] status;
  } evt_t;
`endif

  typedef enum logic {
    ST_IDLE,
    ST_FILTER
  } state_e;

endpackage

// File: rtl/status_event_queue_if.sv
// Event drain handshake between the status event queue and the register/interrupt block.
interface status_event_queue_if;
  import status_event_queue_pkg::*;

  logic [EVT_W-1:0] evt_data;
  logic             evt_valid;
  logic             evt_ready;

  modport master (output evt_data, output evt_valid, input evt_ready);
  modport slave  (input evt_data, input evt_valid, output evt_ready);

endinterface

// File: rtl/status_evt_fifo.sv
// Event FIFO with registered head word; a push on a full FIFO succeeds only alongside a pop.
module status_evt_fifo #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic [W-1:0]         data_i,
  input  logic                 ready_i,
  output logic [W-1:0]         data_o,
  output logic                 valid_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                 drop_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [W-1:0]     data_q, data_d;
  logic             valid_q;
  logic             pop_c, full_c, wr_en_c;

  // Next head word bypasses storage when the entry being written becomes the head.
  always_comb begin
    pop_c   = valid_q && ready_i;
    full_c  = (lvl_q == LVL_W'(DEPTH));
    wr_en_c = push_i && (!full_c || pop_c);
    drop_c  = push_i && full_c && !pop_c;
    rd_d    = pop_c   ? rd_q + PTR_W'(1) : rd_q;
    wr_d    = wr_en_c ? wr_q + PTR_W'(1) : wr_q;
    lvl_d   = lvl_q + LVL_W'(wr_en_c) - LVL_W'(pop_c);
    data_d  = (wr_en_c && (rd_d == wr_q)) ? data_i : mem_q[rd_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      lvl_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      lvl_q   <= lvl_d;
      data_q  <= data_d;
      valid_q <= (lvl_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_q] <= data_i;
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign level_o = lvl_q;

endmodule

// File: rtl/status_event_queue.sv
// Glitch-filters the input-status word and queues each committed change as an event.
// Define STATUS_EVT_TSTAMP_EN to tag events with a free-running 8-bit timestamp.
module status_event_queue
  import status_event_queue_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 3,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   sample_en,
  input  logic [STATUS_W-1:0]    status_in,
  status_event_queue_if.master   evt_if,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [OVF_W-1:0]       ovf_cnt,
  input  logic                   clr_ovf
);

  localparam logic [3:0] STAB_TGT = 4'(STABLE_CYCLES);

  state_e              state_q, state_d;
  logic [STATUS_W-1:0] commit_q, commit_d;
  logic [STATUS_W-1:0] cand_q, cand_d;
  logic [3:0]          stab_q, stab_d;
  logic [OVF_W-1:0]    ovf_q, ovf_d;
  logic                push_c, drop_c;
  evt_t                evt_c;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      commit_q <= '0;
      cand_q   <= '0;
      stab_q   <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      commit_q <= commit_d;
      cand_q   <= cand_d;
      stab_q   <= stab_d;
      ovf_q    <= ovf_d;
    end
  end

  // Filter: a candidate must repeat STABLE_CYCLES samples in a row to become committed.
  always_comb begin
    state_d  = state_q;
    commit_d = commit_q;
    cand_d   = cand_q;
    stab_d   = stab_q;
    push_c   = 1'b0;
    if (sample_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (status_in != commit_q) begin
            cand_d = status_in;
            stab_d = 4'd1;
            if (STAB_TGT == 4'd1) begin
              commit_d = status_in;
              push_c   = 1'b1;
            end else begin
              state_d = ST_FILTER;
            end
          end
        end
        ST_FILTER: begin
          if (status_in == cand_q) begin
            stab_d = stab_q + 4'd1;
            if ((stab_q + 4'd1) == STAB_TGT) begin
              commit_d = cand_q;
              push_c   = 1'b1;
              state_d  = ST_IDLE;
            end
          end else if (status_in == commit_q) begin
            state_d = ST_IDLE;
          end else begin
            cand_d = status_in;
            stab_d = 4'd1;
          end
        end
      endcase
    end
  end

  // A clear always wins over a coincident drop.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) begin
      ovf_d = '0;
    end else if (drop_c && (ovf_q != '1)) begin
      ovf_d = ovf_q + OVF_W'(1);
    end
  end

`ifdef STATUS_EVT_TSTAMP_EN
  logic [TSTAMP_W-1:0] ts_q;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_q + TSTAMP_W'(1);
  end

  assign evt_c = '{tstamp: ts_q, status: status_in};
`else
  assign evt_c = '{status: status_in};
`endif

  status_evt_fifo #(
    .W     (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (sysclk),
    .rst_n   (reset),
    .push_i  (push_c),
    .data_i  (evt_c),
    .ready_i (evt_if.evt_ready),
    .data_o  (evt_if.evt_data),
    .valid_o (evt_if.evt_valid),
    .level_o (fifo_level),
    .drop_c  (drop_c)
  );

  assign ovf_cnt = ovf_q;

endmodule
